// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32I pipeline controller: forward-select encoding and stage record.
// Stage IDs live beside stage_t because their width is a parameter of pipe_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_X  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_we;
        logic       is_load;
        logic       is_mem;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, rd: 5'd0, rd_we: 1'b0, is_load: 1'b0, is_mem: 1'b0};

    // Live stage that writes a nonzero register equal to rs (so rs==x0 never matches).
    function automatic logic writes_reg(stage_t s, logic [4:0] rs);
        return s.valid && s.rd_we && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational RAW/load-use detection and operand forward selection for the I instruction.
// PIPE_FORWARD_EN selects bypassing; without it every RAW against X or M stalls.
module pipe_hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  stage_t     x_stage,
    input  stage_t     m_stage,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs1_use,
    input  logic       rs2_use,
    output logic       hazard,
    output fwd_sel_t   fwd_rs1_sel,
    output fwd_sel_t   fwd_rs2_sel
);

    logic x_hit1, x_hit2, m_hit1, m_hit2;
    logic unused_fields;

    always_comb begin
        x_hit1 = writes_reg(x_stage, rs1);
        x_hit2 = writes_reg(x_stage, rs2);
        m_hit1 = writes_reg(m_stage, rs1);
        m_hit2 = writes_reg(m_stage, rs2);
        unused_fields = ^{x_stage.is_load, x_stage.is_mem, m_stage.is_load, m_stage.is_mem};
`ifdef PIPE_FORWARD_EN
        // Only a load in X cannot be bypassed in time.
        hazard = x_stage.is_load && ((rs1_use && x_hit1) || (rs2_use && x_hit2));
        fwd_rs1_sel = x_hit1 ? FWD_X : (m_hit1 ? FWD_M : FWD_RF);
        fwd_rs2_sel = x_hit2 ? FWD_X : (m_hit2 ? FWD_M : FWD_RF);
`else
        hazard = (rs1_use && (x_hit1 || m_hit1)) || (rs2_use && (x_hit2 || m_hit2));
        fwd_rs1_sel = FWD_RF;
        fwd_rs2_sel = FWD_RF;
`endif
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the I/X/M RV32I core with retire marker R: stalls, flushes,
// forwarding and per-stage valid/sequence-ID tracking. Bypassing enabled by PIPE_FORWARD_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ID_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [4:0]      if_rs1,
    input  logic [4:0]      if_rs2,
    input  logic            if_rs1_use,
    input  logic            if_rs2_use,
    input  logic [4:0]      if_rd,
    input  logic            if_rd_we,
    input  logic            if_is_load,
    input  logic            if_is_mem,
    input  logic            x_redirect,
    input  logic            mem_ready,
    output logic            stall_i,
    output logic            stall_all,
    output logic            flush_i,
    output fwd_sel_t        fwd_rs1_sel,
    output fwd_sel_t        fwd_rs2_sel,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic            inst_v_i,
    output logic            inst_v_x,
    output logic            inst_v_m,
    output logic            inst_v_r,
    output logic [ID_W-1:0] ci,
    output logic [ID_W-1:0] cx,
    output logic [ID_W-1:0] cm,
    output logic [ID_W-1:0] cr
);

    stage_t          x_q, x_d, m_q, m_d;
    logic [ID_W-1:0] next_id_q, next_id_d;
    logic [ID_W-1:0] x_id_q, x_id_d, m_id_q, m_id_d, r_id_q, r_id_d;
    logic            r_valid_q, r_valid_d;

    logic            hazard;
    fwd_sel_t        fwd1_raw, fwd2_raw;
    logic            mem_stall, redirect, hold_i, accept;

    pipe_hazard_unit u_hazard (
        .x_stage     (x_q),
        .m_stage     (m_q),
        .rs1         (if_rs1),
        .rs2         (if_rs2),
        .rs1_use     (if_rs1_use),
        .rs2_use     (if_rs2_use),
        .hazard      (hazard),
        .fwd_rs1_sel (fwd1_raw),
        .fwd_rs2_sel (fwd2_raw)
    );

    // Priority: memory stall freezes everything, then redirect, then data hazards.
    always_comb begin
        mem_stall = m_q.valid && m_q.is_mem && !mem_ready;
        redirect  = x_redirect && !mem_stall;
        hold_i    = if_valid && hazard && !redirect && !mem_stall;
        accept    = if_valid && !hold_i && !redirect && !mem_stall;
    end

    always_comb begin
        next_id_d = next_id_q;
        x_d       = x_q;
        x_id_d    = x_id_q;
        m_d       = m_q;
        m_id_d    = m_id_q;
        r_valid_d = 1'b0;
        r_id_d    = r_id_q;
        if (accept) begin
            next_id_d = next_id_q + ID_W'(1);
        end
        if (!mem_stall) begin
            // A held or flushed I slot enters X as a bubble.
            x_d = '{valid: accept, rd: if_rd, rd_we: if_rd_we,
                    is_load: if_is_load, is_mem: if_is_mem};
            x_id_d    = next_id_q;
            m_d       = x_q;
            m_id_d    = x_id_q;
            r_valid_d = m_q.valid;
            r_id_d    = m_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            next_id_q <= '0;
            x_q       <= STAGE_EMPTY;
            x_id_q    <= '0;
            m_q       <= STAGE_EMPTY;
            m_id_q    <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            next_id_q <= next_id_d;
            x_q       <= x_d;
            x_id_q    <= x_id_d;
            m_q       <= m_d;
            m_id_q    <= m_id_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

    always_comb begin
        stall_i     = reset && hold_i;
        stall_all   = reset && mem_stall;
        flush_i     = reset && redirect;
        fwd_rs1_sel = reset ? fwd1_raw : FWD_RF;
        fwd_rs2_sel = reset ? fwd2_raw : FWD_RF;
        rf_we       = reset && m_q.valid && m_q.rd_we && (m_q.rd != 5'd0) && !mem_stall;
        rf_waddr    = m_q.rd;
        inst_v_i    = reset && if_valid && !redirect;
        inst_v_x    = x_q.valid;
        inst_v_m    = m_q.valid;
        inst_v_r    = r_valid_q;
        ci          = next_id_q;
        cx          = x_id_q;
        cm          = m_id_q;
        cr          = r_id_q;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 3-stage RV32I core (I: fetch/decode, X: execute, M: memory/writeback) plus a 1-cycle retire marker R. Tracks per-stage valid bits, destination registers and instruction sequence IDs. Generates stall, flush and operand-forwarding selects. Drives the stage-valid and sequence-ID signals consumed by the trace/Konata logger.

## Interface
Parameters:
- ID_W, 32, width of sequence IDs; IDs wrap modulo 2^ID_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- if_valid  in  1  fetched instruction present at I
- if_rs1, if_rs2  in  5  source register indices of the I instruction
- if_rs1_use, if_rs2_use  in  1  source actually read
- if_rd  in  5  destination index
- if_rd_we  in  1  instruction writes rd
- if_is_load  in  1  instruction is a load
- if_is_mem  in  1  instruction is a load or store
- x_redirect  in  1  taken branch/jump resolved in X (pcv)
- mem_ready  in  1  data memory completes M access this cycle
- stall_i  out  1  hold PC and I register
- stall_all  out  1  freeze I, X, M
- flush_i  out  1  kill instruction in I
- fwd_rs1_sel, fwd_rs2_sel  out  fwd_sel_t  operand source for instruction entering X
- rf_we  out  1  register-file write this cycle (rdv)
- rf_waddr  out  5  write index (rd_m)
- inst_v_i, inst_v_x, inst_v_m, inst_v_r  out  1  stage holds a live instruction
- ci, cx, cm, cr  out  ID_W  sequence ID of the instruction in each stage

## Operation
- next_id counter increments when if_valid && !stall_i && !stall_all && !flush_i. The accepted instruction takes ID next_id as ci.
- Stage registers X, M: {valid, id, rd, rd_we, is_load, is_mem}. Shift I→X→M each cycle unless stall_all.
- R: inst_v_r = registered (M valid && !stall_all); cr = that ID.
- Load-use hazard: X valid && X.is_load && X.rd_we && X.rd≠0 && matching used I source. Response: stall_i=1 and a bubble is inserted into X.
- Redirect: x_redirect && !stall_all → flush_i=1 and a bubble is inserted into X. The X instruction proceeds. Redirect takes priority over load-use; stall_i=0 when flush_i=1.
- Memory stall: M valid && M.is_mem && !mem_ready → stall_all=1. All stage state holds. x_redirect is ignored; the datapath holds it.
- Forwarding select for I instruction sources (rs=0 → FWD_RF):
  - X match with rd_we → FWD_X.
  - Otherwise M match with rd_we → FWD_M.
  - Otherwise FWD_RF.
- rf_we = M valid && M.rd_we && M.rd≠0 && !stall_all; rf_waddr = M.rd.
- Reset (reset==0 at clk edge):
  - All valids 0, all IDs 0, next_id 0.
  - stall/flush outputs 0, fwd selects FWD_RF, rf_we 0.
  - Applies mid-stall; in-flight instructions are discarded.

## Timing
- Stage registers and the R marker are registered.
- stall_i, stall_all, flush_i, fwd_*_sel and rf_we are combinational from the current state and inputs, valid in the same cycle.
- Load-use costs exactly 1 bubble. Redirect costs 1 bubble (killed I slot).
- A mem stall of N cycles extends every stage by N.
- Simultaneous load-use + mem stall: stall_all dominates; the hazard is re-evaluated after release.
- ID wrap: 2^ID_W−1 → 0 without glitching valids.

## Configuration
- PIPE_FORWARD_EN defined: forwarding as above; only load-use stalls.
- Undefined:
  - fwd selects are tied to FWD_RF.
  - Any RAW match against X or M (rd_we, rd≠0) asserts stall_i with a bubble until the producer leaves M.
  - Worst case is 2 bubbles.

## Structure
- Shared package: fwd_sel_t enum {FWD_RF=2'b00, FWD_X=2'b01, FWD_M=2'b10}, and stage record typedef stage_t.
- Sub-module pipe_hazard_unit: combinational RAW/load-use detection and forward-select generation. pipe_ctrl holds all sequential state.

## Test plan
- Reset mid-stream (reset=0 one cycle) → next cycle all inst_v_*=0, ci=cx=cm=cr=0; the next accepted instruction gets ID 0.
- addi x5 then add x6,x5,x5 back-to-back → no stall, fwd_rs1_sel=fwd_rs2_sel=FWD_X; with macro undefined → stall_i high 2 cycles.
- lw x7 then add x8,x7,x0 → stall_i=1 for 1 cycle, X bubble; then fwd_rs1_sel=FWD_M.
- Branch in X with x_redirect=1 while a lw-use hazard is at I → flush_i=1, stall_i=0, inst_v_x=0 next cycle.
- sw in M with mem_ready=0 for 3 cycles → stall_all=1 for 3 cycles, ci/cx/cm frozen, rf_we=0, inst_v_r=0 during stall.
- 2^ID_W+2 instructions with ID_W=4 → ci sequence wraps 15→0 and cr follows 3 cycles later.
